// File: rtl/fp32_pkg.sv
// fp32_pkg: shared definitions for the single-precision FP units.
//   - IEEE-754 single-precision field widths, bias and bit positions
//   - packed constants for +infinity and +0
//   - state encoding for the iterative divider FSM
package fp32_pkg;

    localparam int FP_W        = 32;
    localparam int FP_EXP_W    = 8;
    localparam int FP_MANT_W   = 24;  // includes the implicit 1
    localparam int FP_FRAC_W   = 23;
    localparam int FP_BIAS     = 127;

    localparam int FP_SIGN_POS = 31;
    localparam int FP_EXP_MSB  = 30;
    localparam int FP_EXP_LSB  = 23;
    localparam int FP_FRAC_MSB = 22;

    localparam logic [FP_W-1:0] FP32_POS_INF = 32'h7F80_0000;
    localparam logic [FP_W-1:0] FP32_ZERO    = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        NORM   = 2'd2
    } fp_div_state_e;

endpackage

// File: rtl/fp_mant_div.sv
// fp_mant_div: restoring mantissa divider, one quotient bit per step.
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : capture ma_i/mb_i, clear quotient and iteration counter
//   step_i     : perform one restoring iteration
//   ma_i, mb_i : normalised mantissas (implicit 1 included)
//   q_o        : quotient, floor(ma/mb * 2^(MANT_W)) after MANT_W+1 steps
//   last_o     : high while the final iteration is being performed
module fp_mant_div #(
    parameter int MANT_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [MANT_W-1:0] ma_i,
    input  logic [MANT_W-1:0] mb_i,
    output logic [MANT_W:0]   q_o,
    output logic              last_o
);

    localparam int ITER  = MANT_W + 1;
    localparam int CNT_W = $clog2(ITER + 1);

    logic [MANT_W:0]   rem_q, rem_d;
    logic [MANT_W:0]   diff;
    logic [MANT_W-1:0] mb_q;
    logic [MANT_W:0]   q_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              ge;

    // After a subtract the remainder is below mb (< 2^MANT_W), so the
    // left shift never loses a set bit in the MANT_W+1 bit register.
    always_comb begin
        ge    = (rem_q >= {1'b0, mb_q});
        diff  = ge ? (rem_q - {1'b0, mb_q}) : rem_q;
        rem_d = diff << 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            mb_q  <= '0;
            q_q   <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            rem_q <= {1'b0, ma_i};
            mb_q  <= mb_i;
            q_q   <= '0;
            cnt_q <= '0;
        end else if (step_i) begin
            rem_q <= rem_d;
            q_q   <= {q_q[MANT_W-1:0], ge};
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign q_o    = q_q;
    assign last_o = (cnt_q == CNT_W'(ITER - 1));

endmodule

// File: rtl/fp_div32.sv
// fp_div32: multi-cycle IEEE-754 single-precision divider, result = a / b.
//   clk, reset : clock, asynchronous active-low reset
//   start      : request, sampled only while idle
//   a, b       : packed dividend / divisor
//   busy       : high from acceptance until done
//   done       : one-cycle pulse, result and flags valid from here on
//   result     : packed quotient (truncated)
//   neg, zero, carry, overflow : result sign, +-0, constant 0, +-infinity
// Handshake: start is taken on a rising edge when the FSM is IDLE; busy
// rises after that edge and falls together with the done pulse. Outputs
// hold until the next done. Exponent-0 operands count as zero.
module fp_div32
    import fp32_pkg::*;
#(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8,
    parameter int BIAS   = 127
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        neg,
    output logic        zero,
    output logic        carry,
    output logic        overflow
);

    localparam int EW   = EXP_W + 2;  // signed headroom for ea - eb + bias
    localparam int SPOS = EXP_W + MANT_W - 1;

    fp_div_state_e    state_q;
    logic             sign_q;
    logic [EXP_W-1:0] ea_q, eb_q;
    logic [31:0]      result_q;
    logic             neg_q, zero_q, ovf_q, busy_q, done_q;

    logic             a_zero, b_zero, div_load, div_step, div_last;
    logic [MANT_W:0]  quo;
    logic [EW-1:0]    e_calc;
    logic [MANT_W-2:0] frac;
    logic [31:0]      res_d;
    logic             zero_d, ovf_d;

    assign a_zero   = (a[MANT_W-1 +: EXP_W] == '0);
    assign b_zero   = (b[MANT_W-1 +: EXP_W] == '0);
    assign div_load = (state_q == IDLE) && start && !a_zero && !b_zero;
    assign div_step = (state_q == DIVIDE);

    fp_mant_div #(.MANT_W(MANT_W)) u_mant_div (
        .clk    (clk),
        .rst_n  (reset),
        .load_i (div_load),
        .step_i (div_step),
        .ma_i   ({1'b1, a[MANT_W-2:0]}),
        .mb_i   ({1'b1, b[MANT_W-2:0]}),
        .q_o    (quo),
        .last_o (div_last)
    );

    // Quotient lies in (0.5, 2): its top bit selects the normalisation.
    always_comb begin
        e_calc = {2'b00, ea_q} - {2'b00, eb_q}
               + (quo[MANT_W] ? EW'(BIAS) : EW'(BIAS - 1));
        frac   = quo[MANT_W] ? quo[MANT_W-1:1] : quo[MANT_W-2:0];
        res_d  = {sign_q, e_calc[EXP_W-1:0], frac};
        zero_d = 1'b0;
        ovf_d  = 1'b0;
        // Divisor zero wins over dividend zero, so 0/0 gives infinity.
        if (eb_q == '0) begin
            res_d = {sign_q, {EXP_W{1'b1}}, {(MANT_W-1){1'b0}}};
            ovf_d = 1'b1;
        end else if (ea_q == '0) begin
            res_d  = {sign_q, {(EXP_W+MANT_W-1){1'b0}}};
            zero_d = 1'b1;
        end else if ($signed(e_calc) >= $signed(EW'((1 << EXP_W) - 1))) begin
            res_d = {sign_q, {EXP_W{1'b1}}, {(MANT_W-1){1'b0}}};
            ovf_d = 1'b1;
        end else if ($signed(e_calc) <= $signed(EW'(0))) begin
            res_d  = {sign_q, {(EXP_W+MANT_W-1){1'b0}}};
            zero_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            ea_q     <= '0;
            eb_q     <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sign_q  <= a[SPOS] ^ b[SPOS];
                        ea_q    <= a[MANT_W-1 +: EXP_W];
                        eb_q    <= b[MANT_W-1 +: EXP_W];
                        busy_q  <= 1'b1;
                        state_q <= (a_zero || b_zero) ? NORM : DIVIDE;
                    end
                end
                DIVIDE: begin
                    if (div_last) state_q <= NORM;
                end
                NORM: begin
                    result_q <= res_d;
                    neg_q    <= res_d[SPOS];
                    zero_q   <= zero_d;
                    ovf_q    <= ovf_d;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign neg      = neg_q;
    assign zero     = zero_q;
    assign carry    = 1'b0;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_fp_div32.sv
module tb_fp_div32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, neg, zero, carry, overflow;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        neg;
    logic        zero;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  fp_div32 dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .neg      (neg),
    .zero     (zero),
    .carry    (carry),
    .overflow (overflow)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: present operands before an edge, drop start just after it (E0)
  task automatic launch(input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // count rising edges until done is seen; -1 on timeout
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) return;
    end
    lat = -1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_done"}, {31'b0, done}, 32'd0);
    check({tag, "_result"}, result, 32'h0);
    check({tag, "_flags"}, {28'b0, neg, zero, carry, overflow}, 32'd0);
  endtask

  initial begin
    int lat;
    logic [31:0] exp_res;
    logic [31:0] last_res;

    //            a             b             result        neg   zero  ovf  lat
    vecs[0] = '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b0, 26};
    vecs[1] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 1'b0, 1'b0, 26};
    vecs[2] = '{32'hBF800000, 32'h3F000000, 32'hC0000000, 1'b1, 1'b0, 1'b0, 26};
    vecs[3] = '{32'h7F000000, 32'h00800000, 32'h7F800000, 1'b0, 1'b0, 1'b1, 26};
    vecs[4] = '{32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, 1'b1, 1'b0, 26};
    vecs[5] = '{32'h3F800000, 32'h00000000, 32'h7F800000, 1'b0, 1'b0, 1'b1, 1};
    vecs[6] = '{32'h80000000, 32'h40000000, 32'h80000000, 1'b1, 1'b1, 1'b0, 1};
    vecs[7] = '{32'h00000000, 32'h00000000, 32'h7F800000, 1'b0, 1'b0, 1'b1, 1};
    vecs[8] = '{32'h40000000, 32'h40400000, 32'h3F2AAAAA, 1'b0, 1'b0, 1'b0, 26};
    vecs[9] = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b1, 1'b0, 1'b0, 26};

    // reset state
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_zero_outputs("reset");
    @(negedge clk);
    reset = 1'b1;

    // table-driven vectors
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(vecs[i].res);
      launch(vecs[i].a, vecs[i].b);
      check($sformatf("v%0d_busy", i), {31'b0, busy}, 32'd1);
      wait_done(lat);
      check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      exp_res = exp_q.pop_front();
      check($sformatf("v%0d_result", i), result, exp_res);
      check($sformatf("v%0d_neg", i), {31'b0, neg}, {31'b0, vecs[i].neg});
      check($sformatf("v%0d_zero", i), {31'b0, zero}, {31'b0, vecs[i].zero});
      check($sformatf("v%0d_ovf", i), {31'b0, overflow}, {31'b0, vecs[i].ovf});
      check($sformatf("v%0d_carry", i), {31'b0, carry}, 32'd0);
      check($sformatf("v%0d_busy_end", i), {31'b0, busy}, 32'd0);
      @(posedge clk);
      #1 check($sformatf("v%0d_done_pulse", i), {31'b0, done}, 32'd0);
    end
    last_res = 32'hC0400000;

    // start and operand changes while busy are ignored; result holds meanwhile
    launch(32'h40C00000, 32'h40000000);
    repeat (4) @(posedge clk);
    #1 check("busy_hold_result", result, last_res);
    @(negedge clk);
    a = 32'h3F800000;
    b = 32'h40400000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat);
    check("busy_ign_lat", lat, 21);
    check("busy_ign_result", result, 32'h40400000);
    @(posedge clk);
    #1 check("busy_ign_no_second_done", {31'b0, done}, 32'd0);
    check("busy_ign_idle", {31'b0, busy}, 32'd0);

    // back-to-back: start raised during the done cycle is accepted
    launch(32'h3F800000, 32'h40400000);
    wait_done(lat);
    check("b2b_first_lat", lat, 26);
    check("b2b_first_result", result, 32'h3EAAAAAA);
    a = 32'hBF800000;
    b = 32'h3F000000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("b2b_accept_busy", {31'b0, busy}, 32'd1);
    check("b2b_hold_result", result, 32'h3EAAAAAA);
    wait_done(lat);
    check("b2b_second_lat", lat, 26);
    check("b2b_second_result", result, 32'hC0000000);
    check("b2b_second_neg", {31'b0, neg}, 32'd1);

    // reset dropped at iteration 10 aborts with no done
    launch(32'h40C00000, 32'h40000000);
    repeat (10) @(posedge clk);
    #1 reset = 1'b0;
    #1 check_zero_outputs("abort");
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1 if (done) check("abort_no_done", {31'b0, done}, 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (30) @(posedge clk);
    #1 check_zero_outputs("abort_after");

    // recovery after abort
    launch(32'h40000000, 32'h40400000);
    wait_done(lat);
    check("recover_lat", lat, 26);
    check("recover_result", result, 32'h3F2AAAAA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_div32.md
# fp_div32

Multi-cycle IEEE-754 single-precision divider for the processor's floating-point path. It computes `a / b` with a start/done handshake and produces the same packed result and `neg/zero/carry/overflow` flag set as the combinational FP adder. The adder is the single-cycle additive unit; this block is the iterative multiplicative-inverse unit alongside it, selected by the FP ALU decode and stalling the datapath while `busy` is high.

## Interface
Parameters:
- `MANT_W`, 24: mantissa width including the implicit 1.
- `EXP_W`, 8: exponent field width.
- `BIAS`, 127: exponent bias.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset (the block resets while `reset`=0).
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  32  dividend (packed IEEE-754).
- `b`  in  32  divisor (packed IEEE-754).
- `busy`  out  1  high from start acceptance until done.
- `done`  out  1  single-cycle pulse; `result` and flags are valid from this point.
- `result`  out  32  packed quotient.
- `neg`  out  1  result sign.
- `zero`  out  1  result is ±0.
- `carry`  out  1  always 0.
- `overflow`  out  1  result is ±infinity (exponent overflow or divide by zero).

## Operation
- Number model: an operand with exponent 0 is treated as zero. All other operands are normals with an implicit 1. Inf/NaN inputs are not special-cased. Rounding is truncation.
- On accept, `a`, `b`, and the sign `sa^sb` are latched. Later changes on `a`/`b` are ignored.
- FSM states and transitions:
  - IDLE → DIVIDE when `start`=1 and both operands are nonzero.
  - IDLE → NORM when `start`=1 and a special case applies.
  - DIVIDE → NORM after 25 iterations.
  - NORM → IDLE.
- DIVIDE (restoring): remainder is 25 bits, initialised to `ma`. For each of 25 iterations:
  - if `rem >= mb`, set the quotient bit to 1 and `rem -= mb`;
  - then shift `rem` left by 1.
  - Quotient bits are produced MSB first, giving `q[24:0] = floor(ma/mb · 2^24)`.
- NORM:
  - Exponent is computed as 10-bit signed: `e = ea - eb + 127` if `q[24]`=1, else `ea - eb + 126`.
  - Mantissa is `q[23:1]` if `q[24]`=1, else `q[22:0]`.
  - If `e >= 255`: result is `{s, 8'hFF, 0}` and `overflow`=1.
  - If `e <= 0`: result is `{s, 0, 0}` and `zero`=1.
- Special cases (`b` exponent checked first):
  - `b` is zero: result is `{s, 8'hFF, 0}`, `overflow`=1. This includes 0/0.
  - `a` is zero: result is `{s, 0, 0}`, `zero`=1.
- Flags in all cases: `neg` = result[31], `carry` = 0.

## Timing
- Reset: state is IDLE. `busy`, `done`, `result`, `neg`, `zero`, `carry`, `overflow` are all 0, and iteration state is cleared. Reset asserted mid-operation aborts immediately; no `done` is produced.
- Normal path: `start` is sampled at edge E0 and `busy`=1 after E0. Iterations run on E1..E25. At E26 the outputs are registered, `done`=1 for exactly one cycle, and `busy`=0. Latency is 26 cycles.
- Special path: outputs are registered and `done` pulses after E1. Latency is 1 cycle.
- `start` while `busy`=1 is ignored; there is no queuing.
- `start` in the cycle `done` is high is accepted, because the FSM is back in IDLE.
- `result` and flags hold their values until the next `done`. They do not change during computation.

## Structure
- Shared package `fp32_pkg` holds:
  - field widths, `BIAS`, and the sign/exponent/mantissa bit positions;
  - `FP32_POS_INF` and `FP32_ZERO` constants;
  - the FSM state enum (IDLE, DIVIDE, NORM).
- One sub-module, `fp_mant_div`: the 25-iteration restoring mantissa divider with a `load`/`step` interface and its own iteration counter, returning `q[24:0]`.
- The top level holds the FSM, the operand latches, exponent/special-case logic, and output packing.

## Test plan
- 6.0/2.0 (`0x40C00000`/`0x40000000`) → `result` = `0x40400000`, `neg`=0, `zero`=0, `done` exactly 26 cycles after `start`.
- 1.0/3.0 (`0x3F800000`/`0x40400000`) → `0x3EAAAAAA` (truncated). Then -1.0/0.5 (`0xBF800000`/`0x3F000000`) → `0xC0000000`, `neg`=1.
- Overflow, 0x7F000000/0x00800000 → `0x7F800000`, `overflow`=1. Underflow, 0x00800000/0x7F000000 → `0x00000000`, `zero`=1.
- Divide by zero, 1.0/0x00000000 → `0x7F800000`, `overflow`=1, `done` 1 cycle after `start`. Zero dividend, 0x80000000/2.0 → `0x80000000`, `zero`=1, `neg`=1.
- Handshake:
  - `start` pulsed and `a`/`b` changed while `busy` → ignored, and the original result is returned.
  - Back-to-back `start` in the `done` cycle → accepted.
  - `reset` dropped at iteration 10 → all outputs 0, no `done`.
